enemy_fire_sched: RTL

Pseudo-random fire scheduler for the enemy formation. Decides when and which enemy shoots, and issues a one-cycle fire pulse to that enemy's missile controller's fire-request input. It sits directly upstream of the per-enemy missile controllers. Only enemies that are alive and have no missile in flight are eligible.

---
 rtl/enemy_pkg.sv | 19 +
 rtl/enemy_lfsr.sv | 25 ++
 rtl/enemy_fire_sched.sv | 114 +++++++++++
 3 files changed

// File: rtl/enemy_pkg.sv
// Shared definitions for enemy-side logic: FSM encoding, LFSR constants and
// the cooldown counter width.
package enemy_pkg;

  typedef enum logic [1:0] {
    ST_COOLDOWN = 2'b00,
    ST_SELECT   = 2'b01
  } fire_state_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;
  localparam int          CNT_W             = 22;

  // Right-shifting Galois step: the bit shifted out feeds back through the taps.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/enemy_lfsr.sv
// Free-running 16-bit Galois LFSR with a seedable synchronous reset, shared by
// any enemy logic that needs cheap pseudo-random bits.
module enemy_lfsr
  import enemy_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge pclk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/enemy_fire_sched.sv
// Enemy fire scheduler: waits out a cooldown, then scans from an LFSR-chosen
// enemy for one that can shoot. Define FIRE_SCHED_JITTER_EN for random extra cooldown.
module enemy_fire_sched
  import enemy_pkg::*;
#(
  parameter int          N_ENEMIES   = 8,
  parameter int          COOLDOWN    = 2_000_000,
  parameter logic [17:0] JITTER_MASK = 18'h3FFFF,
  parameter logic [15:0] LFSR_SEED   = DEFAULT_LFSR_SEED,
  localparam int         IDX_W       = $clog2(N_ENEMIES)
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_ENEMIES-1:0] enemy_alive,
  input  logic [N_ENEMIES-1:0] missile_on,
  output logic [N_ENEMIES-1:0] fire,
  output logic [IDX_W-1:0]     fire_idx
);

  logic [15:0]          lfsr;
  logic [N_ENEMIES-1:0] cand;
  logic [CNT_W-1:0]     reload;

  fire_state_t          state_q,    state_d;
  logic [CNT_W-1:0]     counter_q,  counter_d;
  logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [N_ENEMIES-1:0] fire_q,     fire_d;
  logic [IDX_W-1:0]     fire_idx_q, fire_idx_d;

  enemy_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .pclk (pclk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign cand = enemy_alive & ~missile_on;

`ifdef FIRE_SCHED_JITTER_EN
  assign reload = CNT_W'(COOLDOWN) + CNT_W'({2'b00, lfsr} & JITTER_MASK);
`else
  logic cfg_unused;
  assign cfg_unused = ^{JITTER_MASK, lfsr[15:IDX_W]};
  assign reload     = CNT_W'(COOLDOWN);
`endif

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    scan_idx_d = scan_idx_q;
    scan_cnt_d = scan_cnt_q;
    fire_d     = '0;
    fire_idx_d = fire_idx_q;

    if (!enable) begin
      state_d   = ST_COOLDOWN;
      counter_d = reload;
    end else begin
      case (state_q)
        ST_COOLDOWN: begin
          if (counter_q == '0) begin
            state_d    = ST_SELECT;
            scan_idx_d = lfsr[IDX_W-1:0];
            scan_cnt_d = '0;
          end else begin
            counter_d = counter_q - 1'b1;
          end
        end
        ST_SELECT: begin
          // Exactly one position is tested per cycle, against live inputs.
          if (cand[scan_idx_q]) begin
            fire_d[scan_idx_q] = 1'b1;
            fire_idx_d         = scan_idx_q;
            counter_d          = reload;
            state_d            = ST_COOLDOWN;
          end else if (scan_cnt_q == IDX_W'(N_ENEMIES - 1)) begin
            counter_d = reload;
            state_d   = ST_COOLDOWN;
          end else begin
            scan_idx_d = scan_idx_q + 1'b1;
            scan_cnt_d = scan_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = ST_COOLDOWN;
          counter_d = reload;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= ST_COOLDOWN;
      counter_q  <= CNT_W'(COOLDOWN);
      scan_idx_q <= '0;
      scan_cnt_q <= '0;
      fire_q     <= '0;
      fire_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      scan_idx_q <= scan_idx_d;
      scan_cnt_q <= scan_cnt_d;
      fire_q     <= fire_d;
      fire_idx_q <= fire_idx_d;
    end
  end

  assign fire     = fire_q;
  assign fire_idx = fire_idx_q;

endmodule
